// File: rtl/holiday_lights_sequencer.sv
// Holiday lights sequencer: a start/stop button launches a show that rotates an
// N-LED pattern left, then right, then blinks it, cycling until stopped.
module holiday_lights_sequencer #(
  parameter int TICK_DIV = 100000000,
  parameter int ROUNDS   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        button,
  input  logic [2:0]  switch,
  output logic [15:0] led,
  output logic        busy,
  output logic [1:0]  mode
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int RW = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(TICK_DIV - 1);
  localparam logic [RW-1:0] ROUND_LAST = RW'(ROUNDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN_L = 3'd2,
    ST_RUN_R = 3'd3,
    ST_BLINK = 3'd4
  } state_t;

  state_t        state_r, state_nx;
  logic          btn_q_r;
  logic [15:0]   pat_r, pat_nx, led_nx, pat_load_s;
  logic [CW-1:0] cnt_r, cnt_nx;
  logic [3:0]    step_r, step_nx;
  logic [RW-1:0] round_r, round_nx;
  logic          busy_nx, press_s, tick_s;
  logic [1:0]    mode_nx;

  function automatic state_t next_show(input state_t s);
    case (s)
      ST_RUN_L: return ST_RUN_R;
      ST_RUN_R: return ST_BLINK;
      default:  return ST_RUN_L;
    endcase
  endfunction

  // Next-state, LED, counter and registered-output decode
  always_comb begin
    press_s    = button & ~btn_q_r;
    tick_s     = (cnt_r == CNT_LAST);
    pat_load_s = (16'd2 << switch) - 16'd1;
    state_nx   = state_r;
    led_nx     = led;
    pat_nx     = pat_r;
    cnt_nx     = cnt_r;
    step_nx    = step_r;
    round_nx   = round_r;
    case (state_r)
      ST_IDLE: begin
        led_nx = 16'd0;
        if (press_s) state_nx = ST_LOAD;
        else         state_nx = ST_IDLE;
      end
      ST_LOAD: begin
        pat_nx   = pat_load_s;
        led_nx   = pat_load_s;
        cnt_nx   = {CW{1'b0}};
        step_nx  = 4'd0;
        round_nx = {RW{1'b0}};
        state_nx = ST_RUN_L;
      end
      ST_RUN_L, ST_RUN_R, ST_BLINK: begin
        // A stop request wins over any tick or mode advance in the same cycle
        if (press_s) begin
          state_nx = ST_IDLE;
          led_nx   = 16'd0;
          cnt_nx   = {CW{1'b0}};
          step_nx  = 4'd0;
          round_nx = {RW{1'b0}};
        end else if (tick_s) begin
          cnt_nx  = {CW{1'b0}};
          step_nx = step_r + 4'd1;
          case (state_r)
            ST_RUN_L: led_nx = {led[14:0], led[15]};
            ST_RUN_R: led_nx = {led[0], led[15:1]};
            default:  led_nx = (led == 16'd0) ? pat_r : 16'd0;
          endcase
          if (step_r == 4'd15) begin
            if (round_r == ROUND_LAST) begin
              round_nx = {RW{1'b0}};
              state_nx = next_show(state_r);
            end else begin
              round_nx = round_r + RW'(1);
            end
          end else begin
            round_nx = round_r;
          end
        end else begin
          cnt_nx = cnt_r + CW'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
        led_nx   = 16'd0;
      end
    endcase
    case (state_nx)
      ST_IDLE:  begin busy_nx = 1'b0; mode_nx = 2'b00; end
      ST_LOAD:  begin busy_nx = 1'b1; mode_nx = 2'b00; end
      ST_RUN_L: begin busy_nx = 1'b1; mode_nx = 2'b01; end
      ST_RUN_R: begin busy_nx = 1'b1; mode_nx = 2'b10; end
      ST_BLINK: begin busy_nx = 1'b1; mode_nx = 2'b11; end
      default:  begin busy_nx = 1'b0; mode_nx = 2'b00; end
    endcase
  end

  // State, pattern, counters and outputs register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      btn_q_r <= 1'b0;
      pat_r   <= 16'd0;
      led     <= 16'd0;
      cnt_r   <= {CW{1'b0}};
      step_r  <= 4'd0;
      round_r <= {RW{1'b0}};
      busy    <= 1'b0;
      mode    <= 2'b00;
    end else begin
      state_r <= state_nx;
      btn_q_r <= button;
      pat_r   <= pat_nx;
      led     <= led_nx;
      cnt_r   <= cnt_nx;
      step_r  <= step_nx;
      round_r <= round_nx;
      busy    <= busy_nx;
      mode    <= mode_nx;
    end
  end

endmodule

// File: tb/tb_holiday_lights_sequencer.sv
// Bench for holiday_lights_sequencer: directed scenarios plus random button/switch/reset
// traffic, checked against a cycles-since-start arithmetic model of the show.
module tb_holiday_lights_sequencer;

  localparam int TD = 4;
  localparam int RN = 1;
  localparam int MODE_CYC = 16 * RN * TD;

  logic        clk = 1'b0;
  logic        rst;
  logic        button;
  logic [2:0]  sw;
  logic [15:0] led;
  logic        busy;
  logic [1:0]  mode;

  int checks   = 0;
  int failures = 0;

  // model: 0 idle, 1 load, 2 show; m_cyc counts clock edges since the show began
  int          m_phase;
  logic [15:0] m_pat;
  int          m_cyc;
  logic        m_btnq;

  holiday_lights_sequencer #(.TICK_DIV(TD), .ROUNDS(RN)) dut (
    .clk(clk), .rst(rst), .button(button), .switch(sw),
    .led(led), .busy(busy), .mode(mode)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rotl16(input logic [15:0] p, input int n);
    logic [31:0] w;
    w = {16'h0000, p} << (n % 16);
    return w[15:0] | w[31:16];
  endfunction

  function automatic logic [18:0] exp_vec();
    int k, m, j;
    logic [15:0] l;
    logic [1:0]  md;
    if (m_phase == 0) return 19'd0;
    if (m_phase == 1) return {16'h0000, 1'b1, 2'b00};
    k  = m_cyc / TD;
    m  = (k / (16 * RN)) % 3;
    j  = k % (16 * RN);
    md = 2'(m + 1);
    if (m == 0)      l = rotl16(m_pat, j % 16);
    else if (m == 1) l = rotl16(m_pat, (16 - (j % 16)) % 16);
    else             l = ((j % 2) == 0) ? m_pat : 16'h0000;
    return {l, 1'b1, md};
  endfunction

  task automatic cyc();
    logic press;
    @(posedge clk);
    if (rst) begin
      m_phase = 0;
      m_pat   = 16'h0000;
      m_btnq  = 1'b0;
      m_cyc   = 0;
    end else begin
      press = button & ~m_btnq;
      if (m_phase == 0) begin
        if (press) m_phase = 1;
      end else if (m_phase == 1) begin
        m_pat   = 16'((32'd1 << (int'(sw) + 1)) - 1);
        m_phase = 2;
        m_cyc   = 0;
      end else begin
        if (press) m_phase = 0;
        else       m_cyc++;
      end
      m_btnq = button;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; button = 1'b0; sw = 3'b000;
    repeat (3) cyc();
    checks++;
    if ({led, busy, mode} !== 19'd0)
      begin failures++; $display("FAIL reset got=%h exp=%h", {led, busy, mode}, 19'd0); end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if ({led, busy, mode} !== exp_vec() || busy !== 1'b0)
        begin failures++; $display("FAIL idle_hold got=%h exp=%h", {led, busy, mode}, exp_vec()); end
    end
  endtask

  task automatic test_walk();
    sw = 3'b010; button = 1'b1;
    cyc();
    button = 1'b0;
    checks++;
    if (busy !== 1'b1 || mode !== 2'b00)
      begin failures++; $display("FAIL load busy=%b mode=%b exp busy=1 mode=00", busy, mode); end
    cyc();
    checks++;
    if (led !== 16'h0007 || mode !== 2'b01 || busy !== 1'b1)
      begin failures++; $display("FAIL run_l_entry led=%h mode=%b busy=%b exp 0007/01/1", led, mode, busy); end
    repeat (4) cyc();
    checks++;
    if (led !== 16'h000E)
      begin failures++; $display("FAIL first_tick led=%h exp=000e", led); end
    for (int i = 0; i < 196; i++) begin
      cyc();
      checks++;
      if ({led, busy, mode} !== exp_vec())
        begin failures++; $display("FAIL walk cyc=%0d got=%h exp=%h", m_cyc, {led, busy, mode}, exp_vec()); end
      if (m_cyc == 64) begin
        checks++;
        if (led !== 16'h0007 || mode !== 2'b10)
          begin failures++; $display("FAIL to_run_r led=%h mode=%b exp 0007/10", led, mode); end
      end
      if (m_cyc == 68) begin
        checks++;
        if (led !== 16'h8003)
          begin failures++; $display("FAIL run_r_tick led=%h exp=8003", led); end
      end
      if (m_cyc == 128 || m_cyc == 136) begin
        checks++;
        if (led !== 16'h0007 || mode !== 2'b11)
          begin failures++; $display("FAIL blink_on led=%h mode=%b exp 0007/11", led, mode); end
      end
      if (m_cyc == 132) begin
        checks++;
        if (led !== 16'h0000)
          begin failures++; $display("FAIL blink_off led=%h exp=0000", led); end
      end
      if (m_cyc == 192) begin
        checks++;
        if (led !== 16'h0007 || mode !== 2'b01)
          begin failures++; $display("FAIL wrap_run_l led=%h mode=%b exp 0007/01", led, mode); end
      end
    end
  endtask

  task automatic test_switch_ignored();
    button = 1'b1; cyc(); button = 1'b0; cyc();
    checks++;
    if ({led, busy, mode} !== 19'd0)
      begin failures++; $display("FAIL stop got=%h exp=0", {led, busy, mode}); end
    sw = 3'b111; button = 1'b1; cyc(); button = 1'b0; cyc();
    checks++;
    if (led !== 16'h00FF)
      begin failures++; $display("FAIL wide_load led=%h exp=00ff", led); end
    sw = 3'b000;
    for (int i = 0; i < 200; i++) begin
      cyc();
      checks++;
      if ({led, busy, mode} !== exp_vec())
        begin failures++; $display("FAIL sw_ignored cyc=%0d got=%h exp=%h", m_cyc, {led, busy, mode}, exp_vec()); end
      if (m_cyc == 3 * MODE_CYC) begin
        checks++;
        if (led !== 16'h00FF)
          begin failures++; $display("FAIL sw_boundary led=%h exp=00ff", led); end
      end
    end
  endtask

  task automatic test_stop_priority();
    for (int i = 0; i < TD && (m_cyc % TD) != TD - 1; i++) cyc();
    button = 1'b1;
    cyc();
    checks++;
    if ({led, busy, mode} !== 19'd0)
      begin failures++; $display("FAIL stop_on_tick got=%h exp=0", {led, busy, mode}); end
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++;
      if (busy !== 1'b0 || {led, busy, mode} !== exp_vec())
        begin failures++; $display("FAIL held_no_restart got=%h exp=0", {led, busy, mode}); end
    end
    button = 1'b0; cyc();
    sw = 3'($urandom_range(0, 7));
    button = 1'b1; cyc();
    checks++;
    if (busy !== 1'b1 || mode !== 2'b00)
      begin failures++; $display("FAIL repress_load busy=%b mode=%b exp 1/00", busy, mode); end
    button = 1'b0; cyc();
    for (int i = 0; i < 200 && !(m_phase == 2 && m_cyc == MODE_CYC - 1); i++) cyc();
    checks++;
    if (m_phase != 2 || m_cyc != MODE_CYC - 1)
      begin failures++; $display("FAIL advance_wait timeout cyc=%0d exp=%0d", m_cyc, MODE_CYC - 1); end
    button = 1'b1; cyc();
    checks++;
    if ({led, busy, mode} !== 19'd0)
      begin failures++; $display("FAIL stop_on_advance got=%h exp=0", {led, busy, mode}); end
    button = 1'b0; cyc();
  endtask

  task automatic test_reset_mid();
    sw = 3'($urandom_range(1, 7));
    button = 1'b1; cyc(); button = 1'b0; cyc();
    for (int i = 0; i < 300 && m_cyc != 2 * MODE_CYC + 2; i++) cyc();
    checks++;
    if (mode !== 2'b11)
      begin failures++; $display("FAIL reach_blink mode=%b exp=11", mode); end
    rst = 1'b1; cyc(); rst = 1'b0;
    checks++;
    if ({led, busy, mode} !== 19'd0)
      begin failures++; $display("FAIL mid_reset got=%h exp=0", {led, busy, mode}); end
    sw = 3'b000; button = 1'b1; cyc(); button = 1'b0; cyc();
    checks++;
    if (led !== 16'h0001 || mode !== 2'b01)
      begin failures++; $display("FAIL reset_restart led=%h mode=%b exp 0001/01", led, mode); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) button = ~button;
      sw  = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 599) == 0);
      cyc();
      checks++;
      if ({led, busy, mode} !== exp_vec())
        begin failures++; $display("FAIL random i=%0d got=%h exp=%h", i, {led, busy, mode}, exp_vec()); end
    end
    rst = 1'b0;
  endtask

  initial begin
    m_phase = 0; m_pat = 16'h0000; m_cyc = 0; m_btnq = 1'b0;
    rst = 1'b1; button = 1'b0; sw = 3'b000;
    test_reset();
    test_walk();
    test_switch_ignored();
    test_stop_priority();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/holiday_lights_sequencer.md
HOLIDAY_LIGHTS_SEQUENCER -- requirements
Module: holiday_lights_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 100000000, clock cycles per pattern step (>=2).
REQ-002 Parameter ROUNDS, default 2, full 16-step rounds spent in each show mode (>=1).
REQ-003 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port button, input, 1, start/stop request, level, already synchronous to clk.
REQ-006 Port switch, input, 3, pattern width select; lit-LED count = switch+1.
REQ-007 Port led, output, 16, registered LED drive.
REQ-008 Port busy, output, 1, high in every state except IDLE.
REQ-009 Port mode, output, 2, registered state code: 00 IDLE/LOAD, 01 RUN_L, 10 RUN_R, 11 BLINK.

Function
REQ-010 The block SHALL register button into btn_q each cycle; press = button & ~btn_q; a held button SHALL produce exactly one press.
REQ-011 The FSM SHALL have states IDLE, LOAD, RUN_L, RUN_R, BLINK.
REQ-012 IDLE: led=0; press -> LOAD; otherwise stay.
REQ-013 LOAD (exactly one cycle): latch pat = (1 << (switch+1)) - 1 into a 16-bit register; led <= pat; clear tick counter, step, round; -> RUN_L.
REQ-014 switch SHALL be sampled only in LOAD; changes while running SHALL be ignored until the next start.
REQ-015 Tick counter SHALL count 0..TICK_DIV-1 only outside IDLE/LOAD; tick = (count == TICK_DIV-1); count wraps to 0 on tick.
REQ-016 On tick in RUN_L: led <= {led[14:0], led[15]}.
REQ-017 On tick in RUN_R: led <= {led[0], led[15:1]}.
REQ-018 On tick in BLINK: led <= (led == 0) ? pat : 0.
REQ-019 Step counter (4-bit) SHALL increment per tick and wrap 15->0; on wrap, round increments.
REQ-020 When round reaches ROUNDS on a wrap, round SHALL clear and state advances RUN_L -> RUN_R -> BLINK -> RUN_L; the tick's led update happens in the same cycle.
REQ-021 Each mode therefore lasts 16*ROUNDS ticks and led SHALL equal pat at every mode boundary.
REQ-022 A press in RUN_L, RUN_R or BLINK SHALL go to IDLE next cycle with led=0, busy=0, mode=00; stop SHALL take priority over a coincident tick or mode advance.
REQ-023 A press in LOAD SHALL be ignored.
REQ-024 busy and mode SHALL be registered and SHALL change in the same cycle as the state.

Reset
REQ-025 While rst=1 at a clock edge: state=IDLE, led=0, busy=0, mode=00, pat=0, btn_q=0, tick/step/round counters=0; rst SHALL override press and tick.
REQ-026 Reset asserted mid-show SHALL abort the show; the next press SHALL start from LOAD with a freshly sampled switch.

Verification (TICK_DIV=4, ROUNDS=1)
REQ-027 Reset 3 cycles, button=0 -> led=0x0000, busy=0, mode=00; stays there with no press.
REQ-028 switch=010, button rises -> LOAD next cycle, then led=0x0007, mode=01, busy=1; first tick 4 cycles later -> led=0x000E; after 16 ticks -> led=0x0007, mode=10.
REQ-029 Continue -> first RUN_R tick gives led=0x8003; after 16 ticks led=0x0007, mode=11; BLINK ticks alternate 0x0000/0x0007; after 16 ticks led=0x0007, mode=01.
REQ-030 switch=111 at start -> led=0x00FF; switch changed to 000 mid-run -> pattern unchanged through all three modes.
REQ-031 Press during RUN_L coincident with a tick -> next cycle IDLE, led=0; button held high 20 cycles -> no restart; release and re-press -> LOAD.
REQ-032 rst pulsed one cycle during BLINK -> led=0, mode=00, busy=0 next cycle; subsequent press with switch=000 -> led=0x0001.
